// File: rtl/cdb_arbiter_pkg.sv
// Shared widths and constants for the CDB scheduler and its per-producer result FIFOs.
package cdb_arbiter_pkg;

  localparam int ROB_SIZE_WIDTH = 4;
  localparam int CDB_FIFO_DEPTH = 4;
  localparam int CDB_ENTRY_W    = ROB_SIZE_WIDTH + 32;

  localparam logic CDB_SRC_ALU = 1'b0;
  localparam logic CDB_SRC_LSB = 1'b1;

  typedef struct packed {
    logic [ROB_SIZE_WIDTH-1:0] rob_id;
    logic [31:0]               value;
  } cdb_entry_t;

endpackage

// File: rtl/cdb_fifo.sv
// Result FIFO for one CDB producer. The caller only pushes when not full and only pops when
// not empty; flush empties the FIFO and rewinds both pointers.
module cdb_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 36
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [W-1:0]               din,
  output logic [W-1:0]               dout,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty,
  output logic                       full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      // DEPTH is a power of two, so pointer overflow is the modulo wrap.
      if (push) begin
        mem_d[tail_q] = din;
        tail_d        = tail_q + PW'(1);
      end
      if (pop) head_d = head_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign dout  = mem_q[head_q];
  assign count = count_q;
  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin scheduler of ALU and LSB results onto the registered CDB broadcast.
// Define CDB_BYPASS_EN to let an input arriving at an empty FIFO compete in its own cycle.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int DEPTH = CDB_FIFO_DEPTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rdy,
  input  logic                      rob_clear,
  input  logic                      alu_valid,
  input  logic [ROB_SIZE_WIDTH-1:0] alu_rob_id,
  input  logic [31:0]               alu_value,
  input  logic                      lsb_valid,
  input  logic [ROB_SIZE_WIDTH-1:0] lsb_rob_id,
  input  logic [31:0]               lsb_value,
  output logic                      alu_stall,
  output logic                      lsb_stall,
  output logic                      cdb_valid,
  output logic [ROB_SIZE_WIDTH-1:0] cdb_rob_id,
  output logic [31:0]               cdb_value,
  output logic                      cdb_src,
  output logic                      overflow
);

  localparam int CW = $clog2(DEPTH) + 1;

  // Handshake: a producer may present *_valid only while its *_stall is low; results offered
  // when the FIFO is full are dropped and flagged. The CDB has no ready and never back-pressures.
  cdb_entry_t alu_in, lsb_in, alu_head, lsb_head, alu_cand_e, lsb_cand_e;
  logic [CW-1:0] alu_count, lsb_count;
  logic alu_empty, alu_full, lsb_empty, lsb_full;
  logic alu_byp, lsb_byp, alu_cand, lsb_cand;
  logic gnt_alu, gnt_lsb, active, flush;
  logic alu_push, alu_pop, lsb_push, lsb_pop;

  logic                      cdb_valid_q, cdb_valid_d;
  logic [ROB_SIZE_WIDTH-1:0] cdb_rob_id_q, cdb_rob_id_d;
  logic [31:0]               cdb_value_q, cdb_value_d;
  logic                      cdb_src_q, cdb_src_d;
  logic                      overflow_q, overflow_d;
  logic                      last_grant_q, last_grant_d;

  assign alu_in = '{rob_id: alu_rob_id, value: alu_value};
  assign lsb_in = '{rob_id: lsb_rob_id, value: lsb_value};

  cdb_fifo #(.DEPTH(DEPTH), .W(CDB_ENTRY_W)) u_alu_fifo (
    .clk(clk), .rst(rst), .push(alu_push), .pop(alu_pop), .flush(flush),
    .din(alu_in), .dout(alu_head), .count(alu_count), .empty(alu_empty), .full(alu_full)
  );

  cdb_fifo #(.DEPTH(DEPTH), .W(CDB_ENTRY_W)) u_lsb_fifo (
    .clk(clk), .rst(rst), .push(lsb_push), .pop(lsb_pop), .flush(flush),
    .din(lsb_in), .dout(lsb_head), .count(lsb_count), .empty(lsb_empty), .full(lsb_full)
  );

  always_comb begin
    active = rdy & ~rob_clear;
    flush  = rdy & rob_clear;
`ifdef CDB_BYPASS_EN
    alu_byp = alu_empty & alu_valid;
    lsb_byp = lsb_empty & lsb_valid;
`else
    alu_byp = 1'b0;
    lsb_byp = 1'b0;
`endif
    alu_cand   = ~alu_empty | alu_byp;
    lsb_cand   = ~lsb_empty | lsb_byp;
    alu_cand_e = alu_empty ? alu_in : alu_head;
    lsb_cand_e = lsb_empty ? lsb_in : lsb_head;

    // On a tie the source not granted last wins.
    gnt_alu = active & alu_cand & (~lsb_cand | (last_grant_q == CDB_SRC_LSB));
    gnt_lsb = active & lsb_cand & ~gnt_alu;

    // A granted candidate from an empty FIFO is the bypassed input: consumed, never stored.
    alu_pop  = gnt_alu & ~alu_empty;
    lsb_pop  = gnt_lsb & ~lsb_empty;
    alu_push = active & alu_valid & ~alu_full & ~(gnt_alu & alu_empty);
    lsb_push = active & lsb_valid & ~lsb_full & ~(gnt_lsb & lsb_empty);

    overflow_d   = overflow_q | (active & ((alu_valid & alu_full) | (lsb_valid & lsb_full)));
    last_grant_d = last_grant_q;
    cdb_valid_d  = cdb_valid_q;
    cdb_rob_id_d = cdb_rob_id_q;
    cdb_value_d  = cdb_value_q;
    cdb_src_d    = cdb_src_q;
    if (rdy) begin
      cdb_valid_d = gnt_alu | gnt_lsb;
      if (gnt_alu) begin
        cdb_rob_id_d = alu_cand_e.rob_id;
        cdb_value_d  = alu_cand_e.value;
        cdb_src_d    = CDB_SRC_ALU;
        last_grant_d = CDB_SRC_ALU;
      end else if (gnt_lsb) begin
        cdb_rob_id_d = lsb_cand_e.rob_id;
        cdb_value_d  = lsb_cand_e.value;
        cdb_src_d    = CDB_SRC_LSB;
        last_grant_d = CDB_SRC_LSB;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cdb_valid_q  <= 1'b0;
      cdb_rob_id_q <= '0;
      cdb_value_q  <= '0;
      cdb_src_q    <= CDB_SRC_ALU;
      overflow_q   <= 1'b0;
      last_grant_q <= CDB_SRC_LSB;
    end else begin
      cdb_valid_q  <= cdb_valid_d;
      cdb_rob_id_q <= cdb_rob_id_d;
      cdb_value_q  <= cdb_value_d;
      cdb_src_q    <= cdb_src_d;
      overflow_q   <= overflow_d;
      last_grant_q <= last_grant_d;
    end
  end

  // One slot stays free for the result already in flight when stall is first seen.
  assign alu_stall  = (alu_count >= CW'(DEPTH - 1));
  assign lsb_stall  = (lsb_count >= CW'(DEPTH - 1));
  assign cdb_valid  = cdb_valid_q;
  assign cdb_rob_id = cdb_rob_id_q;
  assign cdb_value  = cdb_value_q;
  assign cdb_src    = cdb_src_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed scenarios plus random traffic against a
// queue-based reference model. Honours CDB_BYPASS_EN in the model when defined.
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  localparam int DEPTH = CDB_FIFO_DEPTH;
  localparam int IW    = ROB_SIZE_WIDTH;
  localparam int SW    = 1 + 1 + IW + 32;

  logic clk = 1'b0;
  logic rst, rdy, rob_clear;
  logic alu_valid, lsb_valid;
  logic [IW-1:0] alu_rob_id, lsb_rob_id;
  logic [31:0] alu_value, lsb_value;
  logic alu_stall, lsb_stall, cdb_valid, cdb_src, overflow;
  logic [IW-1:0] cdb_rob_id;
  logic [31:0] cdb_value;

  cdb_arbiter #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rob_clear(rob_clear),
    .alu_valid(alu_valid), .alu_rob_id(alu_rob_id), .alu_value(alu_value),
    .lsb_valid(lsb_valid), .lsb_rob_id(lsb_rob_id), .lsb_value(lsb_value),
    .alu_stall(alu_stall), .lsb_stall(lsb_stall),
    .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id), .cdb_value(cdb_value),
    .cdb_src(cdb_src), .overflow(overflow)
  );

  // clock / reset
  always #5 clk = ~clk;

  // reference model: per-source result queues plus the broadcast register contents
  logic [IW+31:0] alu_q[$];
  logic [IW+31:0] lsb_q[$];
  logic [SW-1:0]  exp_q[$];
  bit             m_last;      // 1 = LSB granted last
  bit             m_ovf;
  bit             m_valid, m_src;
  logic [IW-1:0]  m_id;
  logic [31:0]    m_val;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    alu_q.delete(); lsb_q.delete(); exp_q.delete();
    m_last = 1'b1; m_ovf = 1'b0;
    m_valid = 1'b0; m_src = 1'b0; m_id = '0; m_val = '0;
  endtask

  task automatic model_step();
    logic [IW+31:0] a_c, l_c, a_in, l_in;
    bit a_has, l_has, a_byp, l_byp, ga, gl;
    int a_n, l_n;
    a_n = alu_q.size(); l_n = lsb_q.size();
    a_in = {alu_rob_id, alu_value}; l_in = {lsb_rob_id, lsb_value};
    if (rdy) begin
      if (rob_clear) begin
        alu_q.delete(); lsb_q.delete();
        m_valid = 1'b0;
      end else begin
        a_byp = 1'b0; l_byp = 1'b0;
`ifdef CDB_BYPASS_EN
        a_byp = (a_n == 0) && alu_valid;
        l_byp = (l_n == 0) && lsb_valid;
`endif
        a_has = (a_n > 0) || a_byp;
        l_has = (l_n > 0) || l_byp;
        a_c = (a_n > 0) ? alu_q[0] : a_in;
        l_c = (l_n > 0) ? lsb_q[0] : l_in;
        if (a_has && l_has) ga = m_last;
        else ga = a_has;
        gl = l_has && !ga;
        m_valid = ga || gl;
        if (ga) begin
          {m_id, m_val} = a_c; m_src = 1'b0; m_last = 1'b0;
          if (a_n > 0) void'(alu_q.pop_front());
        end else if (gl) begin
          {m_id, m_val} = l_c; m_src = 1'b1; m_last = 1'b1;
          if (l_n > 0) void'(lsb_q.pop_front());
        end
        if (alu_valid && !(ga && a_n == 0)) begin
          if (a_n < DEPTH) alu_q.push_back(a_in);
          else m_ovf = 1'b1;
        end
        if (lsb_valid && !(gl && l_n == 0)) begin
          if (l_n < DEPTH) lsb_q.push_back(l_in);
          else m_ovf = 1'b1;
        end
      end
    end
    exp_q.push_back({m_valid, m_src, m_id, m_val});
  endtask

  // scoreboard: compare DUT outputs with the oldest expected snapshot
  task automatic check_outputs();
    logic [SW-1:0] e;
    bit ev, es;
    logic [IW-1:0] eid;
    logic [31:0] evl;
    if (exp_q.size() == 0) begin
      chk("exp_q_empty", 64'd1, 64'd0);
    end else begin
      e = exp_q.pop_front();
      {ev, es, eid, evl} = e;
      chk("cdb_valid", 64'(cdb_valid), 64'(ev));
      chk("cdb_rob_id", 64'(cdb_rob_id), 64'(eid));
      chk("cdb_value", 64'(cdb_value), 64'(evl));
      if (ev) chk("cdb_src", 64'(cdb_src), 64'(es));
    end
    chk("alu_stall", 64'(alu_stall), 64'(alu_q.size() >= DEPTH - 1));
    chk("lsb_stall", 64'(lsb_stall), 64'(lsb_q.size() >= DEPTH - 1));
    chk("overflow", 64'(overflow), 64'(m_ovf));
  endtask

  // driver: called at a negedge; applies inputs, advances model, checks after the edge
  task automatic cycle(input bit r, input bit c,
                       input bit av, input logic [IW-1:0] ai, input logic [31:0] ad,
                       input bit lv, input logic [IW-1:0] li, input logic [31:0] ld);
    rdy = r; rob_clear = c;
    alu_valid = av; alu_rob_id = ai; alu_value = ad;
    lsb_valid = lv; lsb_rob_id = li; lsb_value = ld;
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1, 0, 0, '0, '0, 0, '0, '0);
  endtask

  task automatic rand_cycle(input int rdy_pct, input int clr_pct, input int v_pct);
    cycle($urandom_range(0, 99) < rdy_pct, $urandom_range(0, 99) < clr_pct,
          $urandom_range(0, 99) < v_pct, IW'($urandom_range(0, 15)), $urandom,
          $urandom_range(0, 99) < v_pct, IW'($urandom_range(0, 15)), $urandom);
  endtask

  // asynchronous reset asserted between edges; outputs must clear without a clock edge
  task automatic reset_pulse();
    #2 rst = 1'b1;
    alu_valid = 1'b0; lsb_valid = 1'b0; rob_clear = 1'b0; rdy = 1'b1;
    #1;
    chk("rst_cdb_valid", 64'(cdb_valid), 64'd0);
    chk("rst_cdb_rob_id", 64'(cdb_rob_id), 64'd0);
    chk("rst_cdb_value", 64'(cdb_value), 64'd0);
    chk("rst_cdb_src", 64'(cdb_src), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    chk("rst_alu_stall", 64'(alu_stall), 64'd0);
    chk("rst_lsb_stall", 64'(lsb_stall), 64'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; rob_clear = 1'b0;
    alu_valid = 1'b0; alu_rob_id = '0; alu_value = '0;
    lsb_valid = 1'b0; lsb_rob_id = '0; lsb_value = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_q.push_back('0);
    check_outputs();

    // simultaneous results into empty FIFOs: ALU first after reset, LSB next cycle
    cycle(1, 0, 1, IW'(3), 32'h11, 1, IW'(5), 32'h22);
    idle(4);

    // back-pressure: both sources continuously valid until the LSB FIFO overflows
    for (int i = 0; i < 12; i++)
      cycle(1, 0, 1, IW'(i), 32'hA000 + 32'(i), 1, IW'(i + 1), 32'hB000 + 32'(i));
    idle(10);

    // reset mid-traffic, then a single ALU result through the clean arbiter
    for (int i = 0; i < 3; i++)
      cycle(1, 0, 1, IW'(i + 2), $urandom, 1, IW'(i + 7), $urandom);
    reset_pulse();
    cycle(1, 0, 1, IW'(9), 32'hCAFE, 0, '0, '0);
    idle(3);

    // flush with queued entries and a concurrent ALU push
    for (int i = 0; i < 3; i++)
      cycle(1, 0, 1, IW'(i + 1), 32'hD000 + 32'(i), 1, IW'(i + 10), 32'hE000 + 32'(i));
    cycle(1, 1, 1, IW'(15), 32'hDEAD, 0, '0, '0);
    idle(4);

    // rdy freeze with toggling inputs, then drain
    for (int i = 0; i < 3; i++)
      cycle(1, 0, 1, IW'(i + 4), $urandom, 1, IW'(i + 8), $urandom);
    for (int i = 0; i < 5; i++) rand_cycle(0, 30, 80);
    idle(8);

    // random traffic, with a mid-run asynchronous reset
    for (int i = 0; i < 300; i++) rand_cycle(90, 4, 45);
    reset_pulse();
    for (int i = 0; i < 200; i++) rand_cycle(85, 3, 60);
    idle(10);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Result-bus scheduler between the two result producers (RS/ALU and LSB) and the single common data bus (CDB) that feeds RoB, RS and LSB wake-up. Each producer gets a private result FIFO, so two results completing in the same cycle are never lost. A round-robin arbiter drains the FIFOs onto one registered broadcast per cycle. The block drives back-pressure to the RS dispatch side and the LSB, and is flushed by RoB clear.

## Interface
- `DEPTH`, 4: entries per producer FIFO, power of two, ≥2.
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `rdy` in 1: global ready; low freezes all state.
- `rob_clear` in 1: mispredict flush from RoB.
- `alu_valid` in 1: ALU result valid.
- `alu_rob_id` in `ROB_SIZE_WIDTH`: ALU result tag.
- `alu_value` in 32: ALU result.
- `lsb_valid` in 1: LSB result valid.
- `lsb_rob_id` in `ROB_SIZE_WIDTH`: LSB result tag.
- `lsb_value` in 32: LSB result.
- `alu_stall` out 1: RS must not dispatch to the ALU this cycle.
- `lsb_stall` out 1: LSB must not complete a new load this cycle.
- `cdb_valid` out 1: broadcast valid (registered).
- `cdb_rob_id` out `ROB_SIZE_WIDTH`: broadcast tag (registered).
- `cdb_value` out 32: broadcast data (registered).
- `cdb_src` out 1: 0 = ALU, 1 = LSB (registered).
- `overflow` out 1: sticky; a push arrived while its FIFO was full.

## Operation
- Per source FIFO: count width `$clog2(DEPTH)+1`; head and tail pointers wrap modulo DEPTH.
- Push: on `*_valid` when not full.
- Pop: when the source is granted.
- Push and pop in the same cycle: count is unchanged.
- Push while full: the entry is dropped and `overflow` is set (cleared only by `rst`).
- `*_stall` = count ≥ DEPTH-1. Combinational from count. This leaves one slot for the result already in the ALU pipeline.
- Arbitration: the candidate for each source is its FIFO head; with bypass compiled in, an empty FIFO's candidate is the live input instead.
  - One candidate: it wins.
  - Both candidates: the source not granted last wins.
  - `last_grant` updates only on a grant.
- Grant loads the output registers: `cdb_valid`=1, plus tag, value and `cdb_src`.
- No grant: `cdb_valid`=0; tag and value hold their previous values.
- `rdy`=0: no push, no pop, no output update, no flag change. Inputs in that cycle are ignored.
- `rob_clear` (when `rdy`=1):
  - Both FIFOs empty and pointers zero at the next edge.
  - `cdb_valid`=0 at the next edge.
  - Inputs presented in the clear cycle are dropped.
  - `last_grant` is unchanged.
- `rst` (asynchronous):
  - Counts and pointers are 0.
  - `cdb_valid`=0, `cdb_rob_id`=0, `cdb_value`=0, `cdb_src`=0.
  - `overflow`=0.
  - `last_grant`=1, so the ALU wins the first tie.
  - Both stalls read 0.

## Timing
- FIFO path: push at edge N, head pops at edge N+1, so `cdb_valid` is high in cycle N+1. Latency is 2 edges from the input cycle.
- Bypass path (macro on): input arrives at an empty FIFO and is granted in cycle N, so `cdb_valid` is high after edge N. Latency is 1.
- Bypassed input that loses arbitration: it is pushed into its FIFO normally.
- Throughput: one broadcast per cycle. Both sources continuously valid alternate ALU, LSB, ALU, …
- Stall reacts in the same cycle as the count change, i.e. one cycle after the push edge.

## Configuration
- `CDB_BYPASS_EN` defined: an empty-FIFO input is an arbitration candidate in its own cycle (1-cycle latency).
- `CDB_BYPASS_EN` undefined: only FIFO heads compete; every result takes 2 cycles; input-to-output paths are purely registered.
- Ordering within a source is FIFO in both modes.

## Structure
- `config.v` holds:
  - `ROB_SIZE_WIDTH` (existing).
  - New `CDB_FIFO_DEPTH` default (4).
  - `CDB_SRC_ALU`=0 and `CDB_SRC_LSB`=1 constants.
- One sub-module, `cdb_fifo`:
  - Parameterized depth and data width; data width is `ROB_SIZE_WIDTH`+32.
  - Exposes `count`, `empty`, `full`, head data, `push`, `pop`, `flush`.
  - Instantiated twice.
- The arbiter, bypass mux and output registers live in `cdb_arbiter`.

## Test plan
- Reset mid-traffic: 2 entries in each FIFO, assert `rst` between edges → outputs immediately 0, counts 0, next ALU push appears 2 cycles later (1 with bypass).
- Simultaneous results: ALU (id 3, 0x11) and LSB (id 5, 0x22) valid in the same cycle, FIFOs empty → CDB shows id 3 then id 5 in consecutive cycles, ALU first after reset.
- Back-pressure: LSB pushes DEPTH-1 results while the ALU is continuously valid → `lsb_stall` rises once count reaches 3; one further push is accepted with `overflow`=0; a push at count 4 sets `overflow`=1.
- Flush: 3 queued entries, assert `rob_clear` with a concurrent ALU push → `cdb_valid`=0 next cycle, no queued or concurrent tag ever broadcast.
- `rdy` freeze: hold `rdy`=0 for 5 cycles with inputs toggling → counts, outputs and `last_grant` unchanged; resuming drains the original entries in order.
- Bypass check: single ALU result into an empty arbiter → `cdb_valid` after 1 edge with `CDB_BYPASS_EN`, after 2 without.
